// File: rtl/axi4_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_rd_arbiter
//   Two-master to one-slave AXI4 read arbiter. One burst is in flight at a
//   time: an AR request is granted in IDLE, replayed downstream from a holding
//   register in ADDR, and the R burst is routed back to the granted master in
//   DATA until the RLAST handshake.
//
// Ports
//   aclk, aresetn        clock (rising edge), asynchronous active-low reset
//   s0_* / s1_*          upstream slave ports: full AR and R channels, plus the
//                        write handshake signals, which are tied off here
//   m_*                  downstream master port: full AR and R channels, write
//                        channels driven idle, write responses ignored
// ---------------------------------------------------------------------------
module axi4_rd_arbiter #(
    parameter int N_BYTES    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 4,
    parameter bit RR_EN      = 1'b1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // upstream port 0
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    input  logic [ID_WIDTH-1:0]     s0_arid,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic [7:0]              s0_arlen,
    input  logic [2:0]              s0_arsize,
    input  logic [1:0]              s0_arburst,
    input  logic                    s0_arlock,
    input  logic [3:0]              s0_arcache,
    input  logic [2:0]              s0_arprot,
    input  logic [3:0]              s0_arqos,
    input  logic [3:0]              s0_arregion,
    input  logic                    s0_aruser,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    output logic [ID_WIDTH-1:0]     s0_rid,
    output logic [8*N_BYTES-1:0]    s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rlast,
    output logic                    s0_ruser,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    output logic [ID_WIDTH-1:0]     s0_bid,
    output logic [1:0]              s0_bresp,
    output logic                    s0_buser,
    // upstream port 1
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    input  logic [ID_WIDTH-1:0]     s1_arid,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic [7:0]              s1_arlen,
    input  logic [2:0]              s1_arsize,
    input  logic [1:0]              s1_arburst,
    input  logic                    s1_arlock,
    input  logic [3:0]              s1_arcache,
    input  logic [2:0]              s1_arprot,
    input  logic [3:0]              s1_arqos,
    input  logic [3:0]              s1_arregion,
    input  logic                    s1_aruser,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    output logic [ID_WIDTH-1:0]     s1_rid,
    output logic [8*N_BYTES-1:0]    s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rlast,
    output logic                    s1_ruser,
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    output logic [ID_WIDTH-1:0]     s1_bid,
    output logic [1:0]              s1_bresp,
    output logic                    s1_buser,
    // downstream port
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arlock,
    output logic [3:0]              m_arcache,
    output logic [2:0]              m_arprot,
    output logic [3:0]              m_arqos,
    output logic [3:0]              m_arregion,
    output logic                    m_aruser,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic [8*N_BYTES-1:0]    m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_ruser,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awlock,
    output logic [3:0]              m_awcache,
    output logic [2:0]              m_awprot,
    output logic [3:0]              m_awqos,
    output logic [3:0]              m_awregion,
    output logic                    m_awuser,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [8*N_BYTES-1:0]    m_wdata,
    output logic [N_BYTES-1:0]      m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wuser,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]              m_bresp,
    input  logic                    m_buser
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } st_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic                  user;
    } ar_t;

    st_t  st_r, st_nxt_s;
    logic g_r, g_nxt_s;          // granted port for the burst in flight
    logic lw_r, lw_nxt_s;        // last winner, drives round-robin priority
    ar_t  ar_r, ar_nxt_s;        // AR holding register replayed in ADDR
    ar_t  s0_ar_s, s1_ar_s;
    logic win_s;                 // arbitration winner this cycle (0/1)
    logic grant_s;               // an AR handshake happens upstream this cycle
    logic sel0_s, sel1_s;        // R channel steered to port 0 / port 1
    logic unused_s;

    assign s0_ar_s = {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock,
                      s0_arcache, s0_arprot, s0_arqos, s0_arregion, s0_aruser};
    assign s1_ar_s = {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock,
                      s1_arcache, s1_arprot, s1_arqos, s1_arregion, s1_aruser};

    // Winner selection: a lone requester wins; on contention round-robin
    // picks the port that did not win last, fixed priority picks port 0.
    always_comb begin
        win_s = 1'b0;
        if (s0_arvalid && s1_arvalid) begin
            win_s = RR_EN ? ~lw_r : 1'b0;
        end else begin
            win_s = s1_arvalid;
        end
    end

    // Next-state logic for the burst FSM and its grant/holding registers.
    always_comb begin
        st_nxt_s = st_r;
        g_nxt_s  = g_r;
        lw_nxt_s = lw_r;
        ar_nxt_s = ar_r;
        grant_s  = 1'b0;
        case (st_r)
            ST_IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    grant_s  = 1'b1;
                    g_nxt_s  = win_s;
                    lw_nxt_s = win_s;
                    ar_nxt_s = win_s ? s1_ar_s : s0_ar_s;
                    st_nxt_s = ST_ADDR;
                end else begin
                    st_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (m_arready) begin
                    st_nxt_s = ST_DATA;
                end else begin
                    st_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (m_rvalid && m_rready && m_rlast) begin
                    st_nxt_s = ST_IDLE;
                end else begin
                    st_nxt_s = ST_DATA;
                end
            end
            default: begin
                st_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, grant and holding registers; port 0 has first priority after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st_r <= ST_IDLE;
            g_r  <= 1'b0;
            lw_r <= 1'b1;
            ar_r <= '0;
        end else begin
            st_r <= st_nxt_s;
            g_r  <= g_nxt_s;
            lw_r <= lw_nxt_s;
            ar_r <= ar_nxt_s;
        end
    end

    // AR: upstream ready is a single-cycle combinational pulse to the winner;
    // downstream AR comes straight from the holding register.
    assign s0_arready = grant_s & ~win_s;
    assign s1_arready = grant_s & win_s;
    assign m_arvalid  = (st_r == ST_ADDR);
    assign m_arid     = ar_r.id;
    assign m_araddr   = ar_r.addr;
    assign m_arlen    = ar_r.len;
    assign m_arsize   = ar_r.size;
    assign m_arburst  = ar_r.burst;
    assign m_arlock   = ar_r.lock;
    assign m_arcache  = ar_r.cache;
    assign m_arprot   = ar_r.prot;
    assign m_arqos    = ar_r.qos;
    assign m_arregion = ar_r.region;
    assign m_aruser   = ar_r.user;

    // R: zero-latency steering to the granted port only while in DATA, so
    // beats offered in IDLE/ADDR are never accepted.
    assign sel0_s    = (st_r == ST_DATA) && (g_r == 1'b0);
    assign sel1_s    = (st_r == ST_DATA) && (g_r == 1'b1);
    assign m_rready  = (sel0_s & s0_rready) | (sel1_s & s1_rready);

    assign s0_rvalid = sel0_s & m_rvalid;
    assign s0_rid    = sel0_s ? m_rid   : '0;
    assign s0_rdata  = sel0_s ? m_rdata : '0;
    assign s0_rresp  = sel0_s ? m_rresp : 2'b00;
    assign s0_rlast  = sel0_s & m_rlast;
    assign s0_ruser  = sel0_s & m_ruser;

    assign s1_rvalid = sel1_s & m_rvalid;
    assign s1_rid    = sel1_s ? m_rid   : '0;
    assign s1_rdata  = sel1_s ? m_rdata : '0;
    assign s1_rresp  = sel1_s ? m_rresp : 2'b00;
    assign s1_rlast  = sel1_s & m_rlast;
    assign s1_ruser  = sel1_s & m_ruser;

    // Write channels are not supported: everything held idle.
    assign s0_awready = 1'b0;
    assign s0_wready  = 1'b0;
    assign s0_bvalid  = 1'b0;
    assign s0_bid     = '0;
    assign s0_bresp   = 2'b00;
    assign s0_buser   = 1'b0;
    assign s1_awready = 1'b0;
    assign s1_wready  = 1'b0;
    assign s1_bvalid  = 1'b0;
    assign s1_bid     = '0;
    assign s1_bresp   = 2'b00;
    assign s1_buser   = 1'b0;

    assign m_awvalid  = 1'b0;
    assign m_awid     = '0;
    assign m_awaddr   = '0;
    assign m_awlen    = 8'd0;
    assign m_awsize   = 3'd0;
    assign m_awburst  = 2'd0;
    assign m_awlock   = 1'b0;
    assign m_awcache  = 4'd0;
    assign m_awprot   = 3'd0;
    assign m_awqos    = 4'd0;
    assign m_awregion = 4'd0;
    assign m_awuser   = 1'b0;
    assign m_wvalid   = 1'b0;
    assign m_wdata    = '0;
    assign m_wstrb    = '0;
    assign m_wlast    = 1'b0;
    assign m_wuser    = 1'b0;
    assign m_bready   = 1'b0;

    assign unused_s = ^{s0_awvalid, s0_wvalid, s0_bready, s1_awvalid, s1_wvalid, s1_bready,
                        m_awready, m_wready, m_bvalid, m_bid, m_bresp, m_buser};

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
module tb_axi4_rd_arbiter;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    // shared stimulus
    logic        s0_arvalid, s0_rready, s0_awvalid, s0_wvalid, s0_bready;
    logic [3:0]  s0_arid;  logic [11:0] s0_araddr;  logic [7:0] s0_arlen;
    logic        s1_arvalid, s1_rready, s1_awvalid, s1_wvalid, s1_bready;
    logic [3:0]  s1_arid;  logic [11:0] s1_araddr;  logic [7:0] s1_arlen;
    logic        m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid;
    logic [31:0] m_rdata;
    logic [3:0]  m_rid;

    // outputs of the round-robin instance
    logic        s0_arready, s0_rvalid, s0_rlast, s0_ruser, s0_awready, s0_wready, s0_bvalid, s0_buser;
    logic [3:0]  s0_rid, s0_bid; logic [31:0] s0_rdata; logic [1:0] s0_rresp, s0_bresp;
    logic        s1_arready, s1_rvalid, s1_rlast, s1_ruser, s1_awready, s1_wready, s1_bvalid, s1_buser;
    logic [3:0]  s1_rid, s1_bid; logic [31:0] s1_rdata; logic [1:0] s1_rresp, s1_bresp;
    logic        m_arvalid, m_arlock, m_aruser, m_rready, m_awvalid, m_awlock, m_awuser;
    logic        m_wvalid, m_wlast, m_wuser, m_bready;
    logic [3:0]  m_arid, m_arcache, m_arqos, m_arregion, m_awid, m_awcache, m_awqos, m_awregion, m_wstrb;
    logic [11:0] m_araddr, m_awaddr; logic [7:0] m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot; logic [1:0] m_arburst, m_awburst;
    logic [31:0] m_wdata;

    // outputs of the fixed-priority instance
    logic        f_s0_arready, f_s0_rvalid, f_s0_rlast, f_s0_ruser, f_s0_awready, f_s0_wready, f_s0_bvalid, f_s0_buser;
    logic [3:0]  f_s0_rid, f_s0_bid; logic [31:0] f_s0_rdata; logic [1:0] f_s0_rresp, f_s0_bresp;
    logic        f_s1_arready, f_s1_rvalid, f_s1_rlast, f_s1_ruser, f_s1_awready, f_s1_wready, f_s1_bvalid, f_s1_buser;
    logic [3:0]  f_s1_rid, f_s1_bid; logic [31:0] f_s1_rdata; logic [1:0] f_s1_rresp, f_s1_bresp;
    logic        f_m_arvalid, f_m_arlock, f_m_aruser, f_m_rready, f_m_awvalid, f_m_awlock, f_m_awuser;
    logic        f_m_wvalid, f_m_wlast, f_m_wuser, f_m_bready;
    logic [3:0]  f_m_arid, f_m_arcache, f_m_arqos, f_m_arregion, f_m_awid, f_m_awcache, f_m_awqos, f_m_awregion, f_m_wstrb;
    logic [11:0] f_m_araddr, f_m_awaddr; logic [7:0] f_m_arlen, f_m_awlen;
    logic [2:0]  f_m_arsize, f_m_arprot, f_m_awsize, f_m_awprot; logic [1:0] f_m_arburst, f_m_awburst;
    logic [31:0] f_m_wdata;

    axi4_rd_arbiter #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4), .RR_EN(1'b1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_arid(s0_arid), .s0_araddr(s0_araddr),
        .s0_arlen(s0_arlen), .s0_arsize(3'd2), .s0_arburst(2'd1), .s0_arlock(1'b0), .s0_arcache(4'h3),
        .s0_arprot(3'd0), .s0_arqos(4'h0), .s0_arregion(4'h0), .s0_aruser(1'b1),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rid(s0_rid), .s0_rdata(s0_rdata),
        .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_ruser(s0_ruser),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_buser(s0_buser),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_arid(s1_arid), .s1_araddr(s1_araddr),
        .s1_arlen(s1_arlen), .s1_arsize(3'd2), .s1_arburst(2'd1), .s1_arlock(1'b0), .s1_arcache(4'h3),
        .s1_arprot(3'd0), .s1_arqos(4'h0), .s1_arregion(4'h0), .s1_aruser(1'b0),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rid(s1_rid), .s1_rdata(s1_rdata),
        .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_ruser(s1_ruser),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_buser(s1_buser),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache),
        .m_arprot(m_arprot), .m_arqos(m_arqos), .m_arregion(m_arregion), .m_aruser(m_aruser),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(2'b00),
        .m_rlast(m_rlast), .m_ruser(1'b0),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
        .m_awprot(m_awprot), .m_awqos(m_awqos), .m_awregion(m_awregion), .m_awuser(m_awuser),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wuser(m_wuser), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(4'h0), .m_bresp(2'b00), .m_buser(1'b0)
    );

    axi4_rd_arbiter #(.N_BYTES(4), .ADDR_WIDTH(12), .ID_WIDTH(4), .RR_EN(1'b0)) dut_fixed (
        .aclk(aclk), .aresetn(aresetn),
        .s0_arvalid(s0_arvalid), .s0_arready(f_s0_arready), .s0_arid(s0_arid), .s0_araddr(s0_araddr),
        .s0_arlen(s0_arlen), .s0_arsize(3'd2), .s0_arburst(2'd1), .s0_arlock(1'b0), .s0_arcache(4'h3),
        .s0_arprot(3'd0), .s0_arqos(4'h0), .s0_arregion(4'h0), .s0_aruser(1'b1),
        .s0_rvalid(f_s0_rvalid), .s0_rready(s0_rready), .s0_rid(f_s0_rid), .s0_rdata(f_s0_rdata),
        .s0_rresp(f_s0_rresp), .s0_rlast(f_s0_rlast), .s0_ruser(f_s0_ruser),
        .s0_awvalid(s0_awvalid), .s0_awready(f_s0_awready), .s0_wvalid(s0_wvalid), .s0_wready(f_s0_wready),
        .s0_bvalid(f_s0_bvalid), .s0_bready(s0_bready), .s0_bid(f_s0_bid), .s0_bresp(f_s0_bresp), .s0_buser(f_s0_buser),
        .s1_arvalid(s1_arvalid), .s1_arready(f_s1_arready), .s1_arid(s1_arid), .s1_araddr(s1_araddr),
        .s1_arlen(s1_arlen), .s1_arsize(3'd2), .s1_arburst(2'd1), .s1_arlock(1'b0), .s1_arcache(4'h3),
        .s1_arprot(3'd0), .s1_arqos(4'h0), .s1_arregion(4'h0), .s1_aruser(1'b0),
        .s1_rvalid(f_s1_rvalid), .s1_rready(s1_rready), .s1_rid(f_s1_rid), .s1_rdata(f_s1_rdata),
        .s1_rresp(f_s1_rresp), .s1_rlast(f_s1_rlast), .s1_ruser(f_s1_ruser),
        .s1_awvalid(s1_awvalid), .s1_awready(f_s1_awready), .s1_wvalid(s1_wvalid), .s1_wready(f_s1_wready),
        .s1_bvalid(f_s1_bvalid), .s1_bready(s1_bready), .s1_bid(f_s1_bid), .s1_bresp(f_s1_bresp), .s1_buser(f_s1_buser),
        .m_arvalid(f_m_arvalid), .m_arready(m_arready), .m_arid(f_m_arid), .m_araddr(f_m_araddr), .m_arlen(f_m_arlen),
        .m_arsize(f_m_arsize), .m_arburst(f_m_arburst), .m_arlock(f_m_arlock), .m_arcache(f_m_arcache),
        .m_arprot(f_m_arprot), .m_arqos(f_m_arqos), .m_arregion(f_m_arregion), .m_aruser(f_m_aruser),
        .m_rvalid(m_rvalid), .m_rready(f_m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(2'b00),
        .m_rlast(m_rlast), .m_ruser(1'b0),
        .m_awvalid(f_m_awvalid), .m_awready(m_awready), .m_awid(f_m_awid), .m_awaddr(f_m_awaddr), .m_awlen(f_m_awlen),
        .m_awsize(f_m_awsize), .m_awburst(f_m_awburst), .m_awlock(f_m_awlock), .m_awcache(f_m_awcache),
        .m_awprot(f_m_awprot), .m_awqos(f_m_awqos), .m_awregion(f_m_awregion), .m_awuser(f_m_awuser),
        .m_wvalid(f_m_wvalid), .m_wready(m_wready), .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb), .m_wlast(f_m_wlast),
        .m_wuser(f_m_wuser), .m_bvalid(m_bvalid), .m_bready(f_m_bready), .m_bid(4'h0), .m_bresp(2'b00), .m_buser(1'b0)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        s0v, s1v, arrdy, rv, rl;
        logic [31:0] rd;
        logic        s0rr, s1rr;
        logic        e_a0, e_a1, e_arv;
        logic [3:0]  e_id;
        logic [11:0] e_addr;
        logic [7:0]  e_len;
        logic        e_mrr, e_v0, e_v1;
        logic [31:0] e_d0, e_d1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s0v, s1v, arrdy, rv, rl, input logic [31:0] rd,
                                input logic s0rr, s1rr, e_a0, e_a1, e_arv, input logic [3:0] e_id,
                                input logic [11:0] e_addr, input logic [7:0] e_len,
                                input logic e_mrr, e_v0, e_v1, input logic [31:0] e_d0, e_d1);
        vec_t v;
        v.s0v = s0v; v.s1v = s1v; v.arrdy = arrdy; v.rv = rv; v.rl = rl; v.rd = rd;
        v.s0rr = s0rr; v.s1rr = s1rr; v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_arv = e_arv;
        v.e_id = e_id; v.e_addr = e_addr; v.e_len = e_len;
        v.e_mrr = e_mrr; v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_d0 = e_d0; v.e_d1 = e_d1;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int b;
        logic w;
        // ---------------- vector table ----------------
        // single s0 read, ARLEN=3, downstream AR accepted at once
        vecs.push_back(mk(1,0,0, 0,0,32'h0, 0,0, 1,0,0, 4'h0,12'h000,8'd0, 0,0,0, 32'h0,32'h0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0, 0,0, 0,0,1, 4'h5,12'h100,8'd3, 0,0,0, 32'h0,32'h0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,0,0, 1,(k == 3),32'hA0 + k, 1,0, 0,0,0, 4'h5,12'h100,8'd3,
                              1,1,0, 32'hA0 + k,32'h0));
        // beat offered while idle must not be accepted
        vecs.push_back(mk(0,0,0, 1,0,32'hEE, 1,1, 0,0,0, 4'h5,12'h100,8'd3, 0,0,0, 32'h0,32'h0));
        // s1 read, ARLEN=7, downstream ARREADY low 5 cycles, RREADY toggling 1010
        vecs.push_back(mk(0,1,0, 0,0,32'h0, 0,0, 0,1,0, 4'h5,12'h100,8'd3, 0,0,0, 32'h0,32'h0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0,0,0, 0,0,32'h0, 0,0, 0,0,1, 4'hA,12'h200,8'd7, 0,0,0, 32'h0,32'h0));
        vecs.push_back(mk(0,0,1, 0,0,32'h0, 0,0, 0,0,1, 4'hA,12'h200,8'd7, 0,0,0, 32'h0,32'h0));
        b = 0;
        for (int i = 0; i < 15; i++) begin
            logic rr;
            rr = ((i % 2) == 0);
            vecs.push_back(mk(0,0,0, 1,(b == 7),32'hB0 + b, 0,rr, 0,0,0, 4'hA,12'h200,8'd7,
                              rr,0,1, 32'h0,32'hB0 + b));
            if (rr) b++;
        end
        vecs.push_back(mk(0,0,0, 1,0,32'hEE, 0,1, 0,0,0, 4'hA,12'h200,8'd7, 0,0,0, 32'h0,32'h0));

        // ---------------- reset ----------------
        aresetn = 1'b0;
        s0_arvalid = 1'b0; s0_rready = 1'b1; s0_awvalid = 1'b0; s0_wvalid = 1'b0; s0_bready = 1'b0;
        s1_arvalid = 1'b0; s1_rready = 1'b1; s1_awvalid = 1'b0; s1_wvalid = 1'b0; s1_bready = 1'b0;
        s0_arid = 4'h5; s0_araddr = 12'h100; s0_arlen = 8'd3;
        s1_arid = 4'hA; s1_araddr = 12'h200; s1_arlen = 8'd7;
        m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h55; m_rid = 4'h0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst.m_arvalid", m_arvalid, 32'd0);
        chk("rst.m_rready", m_rready, 32'd0);
        chk("rst.s0_rvalid", s0_rvalid, 32'd0);
        chk("rst.s1_rvalid", s1_rvalid, 32'd0);
        chk("rst.s0_arready", s0_arready, 32'd0);
        chk("rst.m_araddr", m_araddr, 32'd0);
        next_cycle();
        aresetn = 1'b1;
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // ---------------- table-driven cycles ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            s0_arvalid = vecs[i].s0v; s1_arvalid = vecs[i].s1v; m_arready = vecs[i].arrdy;
            m_rvalid = vecs[i].rv; m_rlast = vecs[i].rl; m_rdata = vecs[i].rd;
            m_rid = s1_arid; s0_rready = vecs[i].s0rr; s1_rready = vecs[i].s1rr;
            @(negedge aclk);
            chk($sformatf("v%0d.s0_arready", i), s0_arready, vecs[i].e_a0);
            chk($sformatf("v%0d.s1_arready", i), s1_arready, vecs[i].e_a1);
            chk($sformatf("v%0d.m_arvalid", i), m_arvalid, vecs[i].e_arv);
            chk($sformatf("v%0d.m_arid", i), m_arid, vecs[i].e_id);
            chk($sformatf("v%0d.m_araddr", i), m_araddr, vecs[i].e_addr);
            chk($sformatf("v%0d.m_arlen", i), m_arlen, vecs[i].e_len);
            chk($sformatf("v%0d.m_rready", i), m_rready, vecs[i].e_mrr);
            chk($sformatf("v%0d.s0_rvalid", i), s0_rvalid, vecs[i].e_v0);
            chk($sformatf("v%0d.s1_rvalid", i), s1_rvalid, vecs[i].e_v1);
            chk($sformatf("v%0d.s0_rdata", i), s0_rdata, vecs[i].e_d0);
            chk($sformatf("v%0d.s1_rdata", i), s1_rdata, vecs[i].e_d1);
            if (vecs[i].e_v1) chk($sformatf("v%0d.s1_rid", i), s1_rid, 32'hA);
            next_cycle();
        end

        // ---------------- reset in the middle of an 8-beat s0 burst ----------------
        s0_arlen = 8'd7; s0_rready = 1'b1; s1_rready = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0;
        s0_arvalid = 1'b1; m_arready = 1'b0;
        @(negedge aclk);
        chk("rst5.grant0", s0_arready, 32'd1);
        next_cycle();
        s0_arvalid = 1'b0; m_arready = 1'b1;
        @(negedge aclk);
        chk("rst5.m_arlen", m_arlen, 32'd7);
        next_cycle();
        m_arready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_rvalid = 1'b1; m_rdata = 32'hD0 + k;
            @(negedge aclk);
            chk("rst5.beat", s0_rdata, 32'hD0 + k);
            next_cycle();
        end
        m_rdata = 32'hD2;
        #2 aresetn = 1'b0;
        #1;
        chk("rst5.async_m_rready", m_rready, 32'd0);
        chk("rst5.async_s0_rvalid", s0_rvalid, 32'd0);
        chk("rst5.async_m_arvalid", m_arvalid, 32'd0);
        next_cycle();
        @(negedge aclk);
        chk("rst5.held_s0_rvalid", s0_rvalid, 32'd0);
        next_cycle();
        aresetn = 1'b1;
        m_rvalid = 1'b0;

        // ---------------- both request continuously: RR alternates, fixed always s0 ----------------
        for (int n = 0; n < 6; n++) begin
            w = n[0];
            s0_arvalid = 1'b1; s1_arvalid = 1'b1; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
            @(negedge aclk);
            chk($sformatf("rr%0d.s0_arready", n), s0_arready, {31'd0, ~w});
            chk($sformatf("rr%0d.s1_arready", n), s1_arready, {31'd0, w});
            chk($sformatf("fx%0d.s0_arready", n), f_s0_arready, 32'd1);
            chk($sformatf("fx%0d.s1_arready", n), f_s1_arready, 32'd0);
            next_cycle();
            m_arready = 1'b1;
            @(negedge aclk);
            chk($sformatf("rr%0d.m_araddr", n), m_araddr, w ? 32'h200 : 32'h100);
            chk($sformatf("rr%0d.no_regrant", n), s0_arready | s1_arready, 32'd0);
            next_cycle();
            m_arready = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_rvalid = 1'b1; m_rlast = (k == 1); m_rdata = 32'hC00 + 32'(n * 16 + k);
                @(negedge aclk);
                chk($sformatf("rr%0d.win_rvalid", n), w ? s1_rvalid : s0_rvalid, 32'd1);
                chk($sformatf("rr%0d.lose_rvalid", n), w ? s0_rvalid : s1_rvalid, 32'd0);
                chk($sformatf("rr%0d.win_rdata", n), w ? s1_rdata : s0_rdata, 32'hC00 + 32'(n * 16 + k));
                chk($sformatf("fx%0d.s0_rvalid", n), f_s0_rvalid, 32'd1);
                next_cycle();
            end
        end

        // ---------------- write traffic is ignored ----------------
        s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        s0_awvalid = 1'b1; s0_wvalid = 1'b1; s0_bready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            chk("wr.s0_awready", s0_awready, 32'd0);
            chk("wr.s0_wready", s0_wready, 32'd0);
            chk("wr.m_awvalid", m_awvalid, 32'd0);
            chk("wr.m_wvalid", m_wvalid, 32'd0);
            if (k == 0) begin
                chk("wr.s0_bvalid", s0_bvalid, 32'd0);
                chk("wr.m_bready", m_bready, 32'd0);
            end
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
